connect_box_staged: RTL

- Parametrised connection box. Selects one of NUM_TRACKS routing tracks, or a configured constant, and drives it onto a core input.
- Successor to the fixed 7-bit / 8-track CB. Adds double-buffered (shadow/active) configuration with explicit commit, an optional output pipeline register with stall, and illegal-select detection with a sticky status flag.
- Sits between the routing fabric and a tile core input; it is programmed over the standard config_addr/config_data/config_en bus.

---
 rtl/connect_box_staged.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/connect_box_staged.sv
// rtl/connect_box_staged.sv - connection box with shadow/active config, deferred commit,
// optional stallable output register and sticky illegal-select status.
module connect_box_staged #(
  parameter int                      WIDTH               = 16,
  parameter int                      NUM_TRACKS          = 8,
  parameter logic [NUM_TRACKS-1:0]   FEEDTHROUGH_OUTPUTS = '1,
  parameter int                      HAS_CONSTANT        = 1,
  parameter logic [WIDTH-1:0]        DEFAULT_VALUE       = '0,
  parameter int                      PIPELINE            = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 config_addr,
  input  logic [31:0]                 config_data,
  input  logic                        config_en,
  input  logic                        stall,
  input  logic [NUM_TRACKS*WIDTH-1:0] in_tracks,
  output logic [31:0]                 read_data,
  output logic [WIDTH-1:0]            out
);

  localparam int   SEL_W    = $clog2(NUM_TRACKS);
  localparam logic CONST_OK = (HAS_CONSTANT != 0);
  localparam logic PIPE_OK  = (PIPELINE != 0);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             const_en;
    logic             out_reg_en;
    logic [WIDTH-1:0] cval;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{sel: '0, const_en: 1'b0, out_reg_en: PIPE_OK, cval: DEFAULT_VALUE};

  cfg_t             shadow_q, shadow_d;
  cfg_t             active_q, active_d;
  logic             pending_q, pending_d;
  logic             defer_q, defer_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] out_reg_q, out_reg_d;

  logic [3:0] addr;
  logic       wr_sel, wr_const, wr_commit, wr_status;
  logic       do_commit;

  assign addr      = config_addr[3:0];
  assign wr_sel    = config_en && (addr == 4'd0);
  assign wr_const  = config_en && (addr == 4'd1);
  assign wr_commit = config_en && (addr == 4'd2);
  assign wr_status = config_en && (addr == 4'd3);
  // A commit requested under stall waits in defer_q for the first unstalled edge.
  assign do_commit = !stall && (wr_commit || defer_q);

  logic             track_ok;
  logic [WIDTH-1:0] track_data;
  logic [WIDTH-1:0] mux_val;
  logic             act_illegal;

  // Loop compare keeps out-of-range selects (sel >= NUM_TRACKS) from indexing past the bus.
  always_comb begin
    track_ok   = 1'b0;
    track_data = '0;
    for (int i = 0; i < NUM_TRACKS; i++) begin
      if (active_q.sel == SEL_W'(i)) begin
        track_ok   = FEEDTHROUGH_OUTPUTS[i];
        track_data = in_tracks[i*WIDTH +: WIDTH];
      end
    end
    act_illegal = !active_q.const_en && !track_ok;
    if (active_q.const_en) begin
      mux_val = active_q.cval;
    end else if (!track_ok) begin
      mux_val = '0;
    end else begin
      mux_val = track_data;
    end
  end

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    defer_d   = defer_q;
    illegal_d = illegal_q;
    out_reg_d = out_reg_q;

    if (wr_sel) begin
      shadow_d.sel        = config_data[SEL_W-1:0];
      shadow_d.const_en   = config_data[8] & CONST_OK;
      shadow_d.out_reg_en = config_data[9] & PIPE_OK;
    end
    if (wr_const) begin
      shadow_d.cval = config_data[WIDTH-1:0];
    end

    // The copy takes the shadow as it stood before this edge; a same-edge write stays pending.
    if (do_commit) begin
      active_d  = shadow_q;
      defer_d   = 1'b0;
      pending_d = 1'b0;
    end else if (wr_commit) begin
      defer_d   = 1'b1;
      pending_d = 1'b1;
    end
    if (wr_sel || wr_const) begin
      pending_d = 1'b1;
    end

    if (wr_status && config_data[1]) begin
      illegal_d = 1'b0;
    end
    if (act_illegal) begin
      illegal_d = 1'b1;
    end

    if (active_q.out_reg_en && !stall) begin
      out_reg_d = mux_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q  <= CFG_RESET;
      active_q  <= CFG_RESET;
      pending_q <= 1'b0;
      defer_q   <= 1'b0;
      illegal_q <= 1'b0;
      out_reg_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      defer_q   <= defer_d;
      illegal_q <= illegal_d;
      out_reg_q <= out_reg_d;
    end
  end

  assign out = active_q.out_reg_en ? out_reg_q : mux_val;

  function automatic logic [31:0] pack_sel(input cfg_t c);
    logic [31:0] r;
    r              = '0;
    r[SEL_W-1:0]   = c.sel;
    r[8]           = c.const_en;
    r[9]           = c.out_reg_en;
    return r;
  endfunction

  always_comb begin
    read_data = '0;
    case (addr)
      4'd0:    read_data = pack_sel(shadow_q);
      4'd1:    read_data = 32'(shadow_q.cval);
      4'd2:    read_data = pack_sel(active_q);
      4'd3:    read_data = {30'b0, illegal_q, pending_q};
      default: read_data = '0;
    endcase
  end

  logic unused_cfg_bits;
  assign unused_cfg_bits = &{1'b0, config_addr[31:4], config_data};

endmodule
